// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: CHANNELS x WIDTH fields, valid/ready handshake, 2-entry skid buffer.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_count / flush_count outputs.
module pipe_stage_reg #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned NOP_CH    = 1,
  parameter logic [31:0] NOP_VALUE = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]               stall_count,
  output logic [31:0]               flush_count
`endif
);

  localparam int unsigned     DW        = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] NopWord  = WIDTH'(NOP_VALUE);
  localparam logic [DW-1:0]   ResetData = DW'(NopWord) << (NOP_CH * WIDTH);

  logic          r_main_valid;
  logic [DW-1:0] r_main_data;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_main_free;

  // Ready depends only on registered state, so there is no in->out ready path.
  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_data    = r_main_data;
  assign w_accept    = in_valid && !r_skid_valid;
  assign w_drain     = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= ResetData;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Any accept on this edge is discarded; only the instruction channel is rewritten.
      r_main_valid                         <= 1'b0;
      r_skid_valid                         <= 1'b0;
      r_main_data[NOP_CH*WIDTH +: WIDTH]   <= NopWord;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_data <= in_data;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (r_main_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (flush && (r_main_valid || r_skid_valid) && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, 100-beat stream, random traffic against a
// queue-based reference model; perf counter checks when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int unsigned W    = 32;
  localparam int unsigned C    = 4;
  localparam int unsigned NCH  = 1;
  localparam logic [31:0] NOPV = 32'h0000_0013;
  localparam int unsigned DW   = W * C;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_count;
  logic [31:0]   flush_count;
`endif

  pipe_stage_reg #(
    .WIDTH    (W),
    .CHANNELS (C),
    .NOP_CH   (NCH),
    .NOP_VALUE(NOPV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] pk(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [DW-1:0] pa(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  // Reference model: ordered list of held beats plus the last value seen on the output.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data;
  bit            m_known;
  logic [31:0]   m_stall;
  logic [31:0]   m_flush;

  function automatic void model_edge();
    bit acc;
    bit drn;
    acc = in_valid && (m_q.size() < 2);
    drn = (m_q.size() > 0) && out_ready;
    if (reset) begin
      m_q.delete();
      m_data  = pk(0, NOPV, 0, 0);
      m_known = 1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (m_q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush && m_q.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (flush) begin
        m_q.delete();
        m_data[NCH*W +: W] = NOPV;
        m_known = 1;
      end else begin
        if (drn) void'(m_q.pop_front());
        if (acc) m_q.push_back(in_data);
        if (m_q.size() > 0) begin
          m_data  = m_q[0];
          m_known = 0;
        end else if (drn) begin
          m_known = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model out_valid", DW'(out_valid), DW'(m_q.size() > 0));
    chk("model in_ready", DW'(in_ready), DW'(m_q.size() < 2));
    if (m_q.size() > 0 || m_known) chk("model out_data", out_data, m_data);
`ifdef PIPE_STAGE_PERF_EN
    chk("model stall_count", DW'(stall_count), DW'(m_stall));
    chk("model flush_count", DW'(flush_count), DW'(m_flush));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [DW-1:0] d);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
  endtask

  typedef struct packed {
    logic          rst;
    logic          fl;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] data;
    logic          ev;
    logic          er;
    logic          cd;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] rst_data;
    logic [DW-1:0] fl_data;
    d0       = pk(32'h4, 32'h2001_0005, 32'h7, 32'h9);
    rst_data = pk(0, NOPV, 0, 0);
    fl_data  = pk(32'h11, NOPV, 32'h11, 32'h11);

    //          rst   fl    iv    ordy  data        ev    er    cd    expected data
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, '0,         1'b0, 1'b1, 1'b1, rst_data};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, d0,         1'b1, 1'b1, 1'b1, d0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,         1'b0, 1'b1, 1'b0, '0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'h1),  1'b1, 1'b1, 1'b1, pa(32'h1)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'hA),  1'b1, 1'b0, 1'b1, pa(32'h1)};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'hB),  1'b1, 1'b0, 1'b1, pa(32'h1)};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, pa(32'hB),  1'b1, 1'b1, 1'b1, pa(32'hA)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, pa(32'hB),  1'b1, 1'b1, 1'b1, pa(32'hB)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,         1'b0, 1'b1, 1'b0, '0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'h11), 1'b1, 1'b1, 1'b1, pa(32'h11)};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'h12), 1'b1, 1'b0, 1'b1, pa(32'h11)};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, '0,         1'b0, 1'b1, 1'b1, fl_data};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, pa(32'hC),  1'b0, 1'b1, 1'b1, fl_data};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,         1'b0, 1'b1, 1'b1, fl_data};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'h21), 1'b1, 1'b1, 1'b1, pa(32'h21)};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, pa(32'h22), 1'b1, 1'b0, 1'b1, pa(32'h21)};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, pa(32'h23), 1'b0, 1'b1, 1'b1, rst_data};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, d0,         1'b1, 1'b1, 1'b1, d0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, '0,         1'b0, 1'b1, 1'b1,
                pk(32'h4, NOPV, 32'h7, 32'h9)};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, pa(32'h31), 1'b1, 1'b1, 1'b1, pa(32'h31)};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,         1'b0, 1'b1, 1'b0, '0};

    m_data  = '0;
    m_known = 0;
    m_stall = 0;
    m_flush = 0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].data);
      step();
      chk($sformatf("tbl[%0d] out_valid", i), DW'(out_valid), DW'(tbl[i].ev));
      chk($sformatf("tbl[%0d] in_ready", i), DW'(in_ready), DW'(tbl[i].er));
      if (tbl[i].cd) chk($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].ed);
    end

    // 100-beat stream at one transfer per cycle, one cycle of latency.
    for (int i = 0; i < 100; i++) begin
      drive(0, 0, 1, 1, pk(i, i + 1000, i + 2000, i + 3000));
      step();
      chk("stream out_valid", DW'(out_valid), DW'(1'b1));
      chk("stream out_data", out_data, pk(i, i + 1000, i + 2000, i + 3000));
    end
    drive(0, 0, 0, 1, '0);
    step();

`ifdef PIPE_STAGE_PERF_EN
    drive(1, 0, 0, 0, '0);
    step();
    drive(0, 0, 1, 1, pa(32'h55));
    step();
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 37; i++) step();
    chk("stall_count after 37", DW'(stall_count), DW'(32'd37));
    force dut.r_stall_count = 32'hFFFF_FFFF;
    m_stall = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    step();
    step();
    chk("stall_count saturated", DW'(stall_count), DW'(32'hFFFF_FFFF));
    drive(0, 0, 1, 0, pa(32'h56));
    step();
    drive(0, 1, 0, 0, '0);
    step();
    chk("flush_count after flush", DW'(flush_count), DW'(32'd1));
`endif

    // Random traffic against the model.
    drive(1, 0, 0, 0, '0);
    step();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
            {$urandom, $urandom, $urandom, $urandom});
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
